// File: rtl/sprite_fetch_arbiter.sv
// sprite_fetch_arbiter: round-robin arbiter sharing one bitmap ROM among NUM_REQ sprite row fetchers.
// Ports:
//   clk, reset  - clock; asynchronous active-high reset
//   req         - per-requester row-fetch request (level)
//   req_row     - packed {bitmap_num[2:0], row[3:0]} per requester, 7 bits each
//   gnt         - one-hot grant pulse, high during the low-byte fetch cycle
//   done        - one-hot completion pulse, row_data valid while high
//   row_data    - fetched row {high byte, low byte}, held until the next fetch completes
//   rom_addr    - byte address to the shared ROM
//   rom_bits    - ROM data, combinational in rom_addr
//   busy        - high whenever a fetch is in progress
module sprite_fetch_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [7*NUM_REQ-1:0]   req_row,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic [15:0]            row_data,
    output logic [7:0]             rom_addr,
    input  logic [7:0]             rom_bits,
    output logic                   busy
);
    localparam int IW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, FETCH_LO, FETCH_HI} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d, win, idx;
    logic [6:0]           row_q, row_d;
    logic [7:0]           lo_q, lo_d, addr_q, addr_d;
    logic [15:0]          data_q, data_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d, done_q, done_d;
    logic                 arb;

    // Scan from owner+NUM_REQ down to owner+1 so the nearest requester after the last owner wins.
    always_comb begin
        win = owner_q;
        idx = owner_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(owner_q) + k) % NUM_REQ);
            if (req[idx]) win = idx;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        row_d   = row_q;
        lo_d    = lo_q;
        addr_d  = addr_q;
        data_d  = data_q;
        gnt_d   = '0;
        done_d  = '0;
        arb     = (state_q == IDLE || state_q == FETCH_HI) && |req;
        if (state_q == FETCH_LO) begin
            lo_d    = rom_bits;
            addr_d  = {row_q, 1'b1};
            state_d = FETCH_HI;
        end
        if (state_q == FETCH_HI) begin
            data_d  = {rom_bits, lo_q};
            done_d  = NUM_REQ'(1) << owner_q;
            state_d = IDLE;
        end
        // Arbitration in FETCH_HI overlaps the next grant with the current done for 2-cycle throughput.
        if (arb) begin
            owner_d = win;
            row_d   = req_row[7*int'(win) +: 7];
            addr_d  = {row_d, 1'b0};
            gnt_d   = NUM_REQ'(1) << win;
            state_d = FETCH_LO;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= IW'(NUM_REQ - 1);
            row_q   <= '0;
            lo_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            row_q   <= row_d;
            lo_q    <= lo_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign row_data = data_q;
    assign rom_addr = addr_q;
    assign busy     = state_q != IDLE;
endmodule
